// File: rtl/conv_psum_seq.sv
// conv_psum_seq
//   Sequencer for the row-organised conv partial-sum buffer. One layer tile is
//   handled per start:
//     1. ACCUM: accepts PE-array psum rows and steps the buffer write-row
//        pointer over num_passes input-channel passes. Pass 0 overwrites a row
//        and later passes accumulate into it.
//     2. Drain: reads the ROWS finished rows back out one at a time and
//        presents each row to the downstream stage.
//     3. DONE: pulses done for one cycle.
//
// Handshakes (strict valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid and its payload stable until that transfer.
//   Ready may depend combinationally on state only. It never depends on valid.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, num_passes     begin a tile (sampled in IDLE); pass count (0 -> 1)
//   psum_valid/ready      PE-array psum row handshake
//   buf_wr_en/row/acc     buffer write strobe, row, 0 overwrite / 1 accumulate
//   buf_rd_en/row         buffer read strobe and row (data valid next cycle)
//   out_valid/ready       drained-row handshake to downstream
//   out_row, out_last     index of the presented row, flag for row ROWS-1
//   busy, done            tile in progress; one-cycle end-of-tile pulse
//   stall_cnt             only with CONV_PSUM_STALL_CNT_EN defined. It counts
//                         downstream stall cycles and starved ACCUM cycles.
//                         It saturates at 16'hFFFF.
//
// Optional feature macro: CONV_PSUM_STALL_CNT_EN

module conv_psum_seq #(
  parameter int ROWS   = 10,
  parameter int ROW_W  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic              buf_wr_en,
  output logic [ROW_W-1:0]  buf_wr_row,
  output logic              buf_acc,
  output logic              buf_rd_en,
  output logic [ROW_W-1:0]  buf_rd_row,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef CONV_PSUM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACCUM    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_OUT   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    wr_row;
  logic [ROW_W-1:0]    rd_row;
  logic [PASS_W-1:0]   pass_cnt;
  logic [PASS_W-1:0]   passes;

  logic start_ok;
  logic beat;
  logic row_wrap;
  logic last_pass;
  logic out_hs;

  assign start_ok  = (state == S_IDLE) && start;
  assign beat      = (state == S_ACCUM) && psum_valid;
  assign row_wrap  = (wr_row == LAST_ROW);
  assign last_pass = (pass_cnt == passes - PASS_W'(1));
  assign out_hs    = (state == S_RD_OUT) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and outputs. Every strobe and row output defaults to 0, so row
  // buses read 0 whenever their strobe is low.
  always_comb begin
    state_nxt  = state;
    psum_ready = 1'b0;
    buf_wr_en  = 1'b0;
    buf_wr_row = '0;
    buf_acc    = 1'b0;
    buf_rd_en  = 1'b0;
    buf_rd_row = '0;
    out_valid  = 1'b0;
    out_row    = '0;
    out_last   = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid) begin
          buf_wr_en  = 1'b1;
          buf_wr_row = wr_row;
          buf_acc    = (pass_cnt != '0);
          if (row_wrap && last_pass) state_nxt = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        buf_rd_en  = 1'b1;
        buf_rd_row = rd_row;
        state_nxt  = S_RD_OUT;
      end
      S_RD_OUT: begin
        out_valid = 1'b1;
        out_row   = rd_row;
        out_last  = (rd_row == LAST_ROW);
        if (out_ready) state_nxt = (rd_row == LAST_ROW) ? S_DONE : S_RD_ISSUE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Row and pass counters. A num_passes of 0 is latched as 1 pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row   <= '0;
      rd_row   <= '0;
      pass_cnt <= '0;
      passes   <= PASS_W'(1);
    end else begin
      if (start_ok) begin
        passes   <= (num_passes == '0) ? PASS_W'(1) : num_passes;
        wr_row   <= '0;
        rd_row   <= '0;
        pass_cnt <= '0;
      end else if (beat) begin
        if (row_wrap) begin
          wr_row <= '0;
          // pass_cnt stays on the final pass; it never exceeds passes-1
          if (!last_pass) pass_cnt <= pass_cnt + PASS_W'(1);
        end else begin
          wr_row <= wr_row + ROW_W'(1);
        end
      end
      if (out_hs && (rd_row != LAST_ROW)) rd_row <= rd_row + ROW_W'(1);
    end
  end

`ifdef CONV_PSUM_STALL_CNT_EN
  logic stall_inc;
  assign stall_inc = ((state == S_RD_OUT) && !out_ready) ||
                     ((state == S_ACCUM) && !psum_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cnt <= '0;
    else if (start_ok)                          stall_cnt <= '0;
    else if (stall_inc && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
